// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the word_loader slice.
//   state_e        : load FSM states (FILL, FULL, DONE)
//   WORD_W         : stored word width (4 bytes)
//   BYTES_PER_WORD : bytes packed into one word
//   BYTE_IDX_W     : width of the byte-within-word index
//   DEFAULT_DEPTH  : default number of stored words
// -----------------------------------------------------------------------------
package loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int BYTE_IDX_W     = 2;
  localparam int DEFAULT_DEPTH  = 256;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/word_loader_if.sv
// -----------------------------------------------------------------------------
// word_loader_if
// Byte-stream valid/ready handshake feeding the word loader.
//   in_valid : source has a byte
//   in_ready : loader can take a byte
//   in_data  : byte payload
//   in_last  : final byte of the load
// Modports: master (byte source), slave (word_loader).
// -----------------------------------------------------------------------------
interface word_loader_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/loader_ram.sv
// -----------------------------------------------------------------------------
// loader_ram
// DEPTH x WORD_W simple dual-port RAM: one write port, one registered read
// port. The array has no reset so it maps onto block RAM. Out-of-range read
// masking is handled by the caller.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, one cycle after raddr
// -----------------------------------------------------------------------------
module loader_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/word_loader.sv
// -----------------------------------------------------------------------------
// word_loader
// Accepts a byte stream and packs it little-endian into 32-bit words stored
// in an internal RAM; a downstream reader fetches them through a registered
// read port once load_done is high.
//
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   clear      : synchronous restart of a load (RAM contents kept)
//   in_bus     : byte stream handshake (slave side)
//   rd_addr    : read address
//   rd_data    : read data, one cycle after rd_addr; 0 if rd_addr was not
//                below word_count on the address cycle
//   word_count : words committed to RAM (saturates at DEPTH)
//   load_done  : high in DONE
//   overflow   : sticky, bytes arrived while RAM full
//   checksum   : mod-2^32 sum of committed words
//
// Optional feature macro: WORD_LOADER_CHECKSUM_EN. When undefined checksum
// is tied to zero and no adder exists.
// -----------------------------------------------------------------------------
module word_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  word_loader_if.slave      in_bus,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              overflow,
  output logic [WORD_W-1:0] checksum
);

  localparam logic [ADDR_W:0]     DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  state_e                  state_q, state_d;
  logic [ADDR_W:0]         word_count_q, word_count_d;
  logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0]       pack_q, pack_d;
  logic                    overflow_q, overflow_d;
  logic                    rd_in_range_q;

  logic                    accept;
  logic                    commit;
  logic                    restart;
  logic [WORD_W-1:0]       assembled;
  logic [WORD_W-1:0]       ram_rdata;

  assign restart = rst || clear;
  assign in_bus.in_ready = (state_q != DONE);
  assign accept = in_bus.in_valid && in_bus.in_ready;

  // Pack register with the incoming byte dropped into its lane. Lanes above
  // byte_idx are still zero in pack_q, which gives zero padding for free.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign assembled[gi*BYTE_W +: BYTE_W] =
        (byte_idx_q == BYTE_IDX_W'(gi)) ? in_bus.in_data
                                         : pack_q[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    byte_idx_d   = byte_idx_q;
    pack_d       = pack_q;
    overflow_d   = overflow_q;
    commit       = 1'b0;

    case (state_q)
      FILL: begin
        if (accept) begin
          if ((byte_idx_q == LAST_IDX) || in_bus.in_last) begin
            commit       = 1'b1;
            word_count_d = word_count_q + 1'b1;
            byte_idx_d   = '0;
            pack_d       = '0;
            if (in_bus.in_last) begin
              state_d = DONE;
            end else if ((word_count_q + 1'b1) == DEPTH_CNT) begin
              state_d = FULL;
            end
          end else begin
            pack_d     = assembled;
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      FULL: begin
        // RAM is full: bytes are consumed and dropped.
        if (accept) begin
          overflow_d = 1'b1;
          if (in_bus.in_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q       <= FILL;
      word_count_q  <= '0;
      byte_idx_q    <= '0;
      pack_q        <= '0;
      overflow_q    <= 1'b0;
      rd_in_range_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_count_q  <= word_count_d;
      byte_idx_q    <= byte_idx_d;
      pack_q        <= pack_d;
      overflow_q    <= overflow_d;
      // Range is judged against the count before this cycle's write, so a
      // read of the word being written returns 0.
      rd_in_range_q <= ({1'b0, rd_addr} < word_count_q);
    end
  end

  loader_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_ram (
    .clk   (clk),
    .we    (commit && !restart),
    .waddr (word_count_q[ADDR_W-1:0]),
    .wdata (assembled),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  assign rd_data    = rd_in_range_q ? ram_rdata : '0;
  assign word_count = word_count_q;
  assign load_done  = (state_q == DONE);
  assign overflow   = overflow_q;

`ifdef WORD_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (restart) begin
      checksum_q <= '0;
    end else if (commit) begin
      checksum_q <= checksum_q + assembled;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_word_loader.sv
// -----------------------------------------------------------------------------
// tb_word_loader
// Two loaders: A (DEPTH=256) and B (DEPTH=4, exercises FULL/overflow).
// Expected RAM image, count, overflow and checksum are derived from the list
// of bytes sent, by chunking it into 4-byte little-endian words.
// -----------------------------------------------------------------------------
module tb_word_loader;

  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst;
  logic clear_a, clear_b;

  word_loader_if bus_a ();
  word_loader_if bus_b ();

  logic [7:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [8:0]  word_count_a;
  logic        load_done_a, overflow_a;
  logic [31:0] checksum_a;

  logic [1:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic [2:0]  word_count_b;
  logic        load_done_b, overflow_b;
  logic [31:0] checksum_b;

  word_loader #(.DEPTH(256)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_a),
    .in_bus     (bus_a),
    .rd_addr    (rd_addr_a),
    .rd_data    (rd_data_a),
    .word_count (word_count_a),
    .load_done  (load_done_a),
    .overflow   (overflow_a),
    .checksum   (checksum_a)
  );

  word_loader #(.DEPTH(4)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_b),
    .in_bus     (bus_b),
    .rd_addr    (rd_addr_b),
    .rd_data    (rd_data_b),
    .word_count (word_count_b),
    .load_done  (load_done_b),
    .overflow   (overflow_b),
    .checksum   (checksum_b)
  );

  always #5 clk = ~clk;

`ifdef WORD_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference image
  logic [31:0] exp_mem [$];
  int          exp_count;
  bit          exp_ovf;
  logic [31:0] exp_sum;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Chunk the byte list into little-endian words, keep what fits.
  task automatic build_model(input byte_t b[$], input int depth);
    int nwords;
    logic [31:0] w;
    exp_mem.delete();
    exp_sum = '0;
    nwords = (b.size() + 3) / 4;
    if (nwords > depth) nwords = depth;
    exp_count = nwords;
    exp_ovf = (b.size() > 4 * depth);
    for (int wi = 0; wi < nwords; wi++) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        if (4 * wi + k < b.size()) w = w + ({24'd0, b[4*wi+k]} << (8 * k));
      end
      exp_mem.push_back(w);
      exp_sum = exp_sum + w;
    end
  endtask

  task automatic drive(input int which, input logic v, input byte_t d, input logic l);
    if (which == 0) begin
      bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_last = l;
    end else begin
      bus_b.in_valid = v; bus_b.in_data = d; bus_b.in_last = l;
    end
  endtask

  task automatic push(input int which, input byte_t d, input logic l, output logic rdy);
    drive(which, 1'b1, d, l);
    rdy = (which == 0) ? bus_a.in_ready : bus_b.in_ready;
    @(posedge clk); #1;
    drive(which, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clear(input int which);
    if (which == 0) clear_a = 1'b1; else clear_b = 1'b1;
    @(posedge clk); #1;
    clear_a = 1'b0; clear_b = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
  task automatic load(input int which, input byte_t b[$], input int gap_mode, input string tag);
    logic rdy;
    logic all_rdy;
    all_rdy = 1'b1;
    for (int i = 0; i < b.size(); i++) begin
      push(which, b[i], (i == b.size() - 1), rdy);
      if (!rdy) all_rdy = 1'b0;
      if (gap_mode == 1) idle(1);
      else if (gap_mode == 2) idle($urandom_range(0, 2));
    end
    check({tag, "_ready"}, all_rdy, 1'b1);
  endtask

  task automatic read(input int which, input int addr, output logic [31:0] data);
    if (which == 0) rd_addr_a = addr[7:0]; else rd_addr_b = addr[1:0];
    @(posedge clk); #1;
    data = (which == 0) ? rd_data_a : rd_data_b;
  endtask

  task automatic verify(input int which, input int depth, input string tag);
    logic [31:0] d;
    int last_addr;
    if (which == 0) begin
      check({tag, "_count"}, word_count_a, exp_count);
      check({tag, "_done"}, load_done_a, 1'b1);
      check({tag, "_ovf"}, overflow_a, exp_ovf);
      check({tag, "_cksum"}, checksum_a, CK_EN ? exp_sum : 32'd0);
    end else begin
      check({tag, "_count"}, word_count_b, exp_count);
      check({tag, "_done"}, load_done_b, 1'b1);
      check({tag, "_ovf"}, overflow_b, exp_ovf);
      check({tag, "_cksum"}, checksum_b, CK_EN ? exp_sum : 32'd0);
    end
    last_addr = exp_count + 1;
    if (last_addr > depth - 1) last_addr = depth - 1;
    for (int a = 0; a <= last_addr; a++) begin
      read(which, a, d);
      check($sformatf("%s_rd%0d", tag, a), d, (a < exp_count) ? exp_mem[a] : 32'd0);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    byte_t       q[$];
    logic        rdy;
    logic [31:0] d;
    int          len;

    rst = 1'b1; clear_a = 1'b0; clear_b = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    check("rst_count", word_count_a, 0);
    check("rst_done", load_done_a, 1'b0);
    check("rst_ovf", overflow_a, 1'b0);
    check("rst_ready", bus_a.in_ready, 1'b1);
    check("rst_rd", rd_data_a, 0);
    check("rst_cksum", checksum_a, 0);
    check("rst_b_count", word_count_b, 0);

    // Two full words
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build_model(q, 256);
    load(0, q, 0, "seq8");
    verify(0, 256, "seq8");
    check("seq8_w0_const", exp_mem[0], 32'h04030201);

    // Partial word with padding, then DONE refuses input
    pulse_clear(0);
    q = '{8'hAA, 8'hBB, 8'hCC};
    build_model(q, 256);
    load(0, q, 0, "pad3");
    verify(0, 256, "pad3");
    check("pad3_ready_done", bus_a.in_ready, 1'b0);
    push(0, 8'h55, 1'b0, rdy);
    push(0, 8'h66, 1'b1, rdy);
    idle(1);
    check("pad3_count_after", word_count_a, 1);
    read(0, 0, d);
    check("pad3_w0_after", d, 32'h00CCBBAA);

    // 400 bytes with valid toggling every other cycle
    pulse_clear(0);
    q.delete();
    for (int i = 0; i < 400; i++) q.push_back(byte_t'($urandom));
    build_model(q, 256);
    load(0, q, 1, "tog400");
    verify(0, 256, "tog400");

    // Random loads of random length
    for (int it = 0; it < 4; it++) begin
      pulse_clear(0);
      q.delete();
      len = $urandom_range(1, 300);
      for (int i = 0; i < len; i++) q.push_back(byte_t'($urandom));
      build_model(q, 256);
      load(0, q, $urandom_range(0, 2), $sformatf("rnd%0d", it));
      verify(0, 256, $sformatf("rnd%0d", it));
    end

    // Clear midway, with a valid byte on the clear cycle
    pulse_clear(0);
    for (int i = 0; i < 6; i++) push(0, byte_t'($urandom), 1'b0, rdy);
    drive(0, 1'b1, 8'hFF, 1'b0);
    clear_a = 1'b1;
    @(posedge clk); #1;
    clear_a = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    q = '{8'h04, 8'h00, 8'h00, 8'h00};
    build_model(q, 256);
    load(0, q, 0, "clr");
    verify(0, 256, "clr");

    // DEPTH=4: 20 bytes, FULL after 16, overflow on 17th
    pulse_clear(1);
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(byte_t'($urandom));
    build_model(q, 4);
    for (int i = 0; i < 20; i++) begin
      push(1, q[i], (i == 19), rdy);
      check($sformatf("b20_ready%0d", i), rdy, 1'b1);
      if (i == 15) begin
        check("b20_full_count", word_count_b, 4);
        check("b20_full_notdone", load_done_b, 1'b0);
        check("b20_full_noovf", overflow_b, 1'b0);
        check("b20_full_ready", bus_b.in_ready, 1'b1);
      end
      if (i == 16) check("b20_ovf_first", overflow_b, 1'b1);
    end
    verify(1, 4, "b20");

    // DEPTH=4 exact fill ends in DONE without overflow
    pulse_clear(1);
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(byte_t'($urandom));
    build_model(q, 4);
    load(1, q, 2, "b16");
    verify(1, 4, "b16");

    // rst on the cycle the fourth byte is accepted: nothing written
    pulse_clear(0);
    for (int i = 0; i < 3; i++) push(0, byte_t'($urandom), 1'b0, rdy);
    drive(0, 1'b1, 8'h99, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    check("rstw_count", word_count_a, 0);
    check("rstw_rd_now", rd_data_a, 0);
    read(0, 0, d);
    check("rstw_rd0", d, 0);
    // Byte index and pack register restarted: a lone byte lands in byte 0
    q = '{8'h5A};
    build_model(q, 256);
    load(0, q, 0, "one");
    verify(0, 256, "one");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
